// File: rtl/execute_unit.sv
// Multi-cycle execute stage for an 8-bit accumulator machine with a 16-word memory.
// Handles direct and indirect memory-reference instructions plus two register ops.
module execute_unit (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       start,
  input  logic       I,
  input  logic [2:0] opcode,
  input  logic [3:0] addr,
  output logic [3:0] mem_addr,
  input  logic [7:0] mem_rdata,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  output logic [7:0] AC,
  output logic       E,
  output logic       busy,
  output logic       done,
  output logic       pc_load,
  output logic [3:0] pc_value
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpXor = 3'b010;
  localparam logic [2:0] OpShl = 3'b011;
  localparam logic [2:0] OpLda = 3'b100;
  localparam logic [2:0] OpSta = 3'b101;
  localparam logic [2:0] OpCma = 3'b110;
  localparam logic [2:0] OpBun = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StIndA,
    StIndD,
    StOpA,
    StOpD,
    StExec
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [3:0] ea_q, ea_d;
  logic [7:0] dr_q, dr_d;
  logic [7:0] ac_q, ac_d;
  logic       e_q, e_d;
  logic [3:0] mem_addr_q, mem_addr_d;
  logic [8:0] sum;

  // Everything except SHL and CMA touches memory through the effective address.
  function automatic logic is_mem_ref(input logic [2:0] op);
    return !(op == OpShl || op == OpCma);
  endfunction

  // Only these opcodes need a data operand fetched into DR.
  function automatic logic needs_operand(input logic [2:0] op);
    return (op == OpAdd) || (op == OpSub) || (op == OpXor) || (op == OpLda);
  endfunction

  // Next-state, address sequencing and accumulator update.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ea_d       = ea_q;
    dr_d       = dr_q;
    ac_d       = ac_q;
    e_d        = e_q;
    mem_addr_d = mem_addr_q;
    sum        = 9'd0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d = opcode;
          ea_d = addr;
          if (is_mem_ref(opcode)) begin
            // Direct ops present EA now; indirect ops present the pointer address.
            mem_addr_d = addr;
          end
          if (is_mem_ref(opcode) && I) begin
            state_d = StIndA;
          end else if (needs_operand(opcode)) begin
            state_d = StOpA;
          end else begin
            state_d = StExec;
          end
        end
      end
      StIndA: begin
        state_d = StIndD;
      end
      StIndD: begin
        // Pointer word arrives now; it becomes EA and the next presented address.
        ea_d       = mem_rdata[3:0];
        mem_addr_d = mem_rdata[3:0];
        state_d    = needs_operand(op_q) ? StOpA : StExec;
      end
      StOpA: begin
        state_d = StOpD;
      end
      StOpD: begin
        dr_d    = mem_rdata;
        state_d = StExec;
      end
      StExec: begin
        state_d = StIdle;
        case (op_q)
          OpAdd: begin
            sum  = {1'b0, ac_q} + {1'b0, dr_q};
            ac_d = sum[7:0];
            e_d  = sum[8];
          end
          OpSub: begin
            ac_d = ac_q - dr_q;
            e_d  = (ac_q >= dr_q);
          end
          OpXor: ac_d = ac_q ^ dr_q;
          OpShl: begin
            sum  = {1'b0, ac_q} + {1'b0, ac_q};
            ac_d = sum[7:0];
            e_d  = sum[8];
          end
          OpLda: ac_d = dr_q;
          OpCma: ac_d = ~ac_q;
          default: begin
            // STA and BUN leave AC and E alone.
          end
        endcase
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      op_q       <= 3'd0;
      ea_q       <= 4'd0;
      dr_q       <= 8'd0;
      ac_q       <= 8'd0;
      e_q        <= 1'b0;
      mem_addr_q <= 4'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ea_q       <= ea_d;
      dr_q       <= dr_d;
      ac_q       <= ac_d;
      e_q        <= e_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Outputs decoded from the current state; all zero while idle or in reset.
  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StExec);
    mem_we    = done && (op_q == OpSta);
    mem_wdata = mem_we ? ac_q : 8'd0;
    pc_load   = done && (op_q == OpBun);
    pc_value  = pc_load ? ea_q : 4'd0;
    mem_addr  = mem_addr_q;
    AC        = ac_q;
    E         = e_q;
  end

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: a driver predicts each instruction's outcome from
// a memory/accumulator model and queues it; a monitor checks the DUT when done pulses.
module tb_execute_unit;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       start;
  logic       I;
  logic [2:0] opcode;
  logic [3:0] addr;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic [7:0] AC;
  logic       E;
  logic       busy;
  logic       done;
  logic       pc_load;
  logic [3:0] pc_value;

  execute_unit dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .I        (I),
    .opcode   (opcode),
    .addr     (addr),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .AC       (AC),
    .E        (E),
    .busy     (busy),
    .done     (done),
    .pc_load  (pc_load),
    .pc_value (pc_value)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Synchronous-read memory: data for an address appears the cycle after it is presented.
  logic [7:0] mem [16];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [7:0] poke_data;
  always @(posedge CLK) begin
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  typedef struct {
    int unsigned done_cyc;
    int unsigned ac;
    int unsigned e;
    bit          we;
    int unsigned waddr;
    int unsigned wdata;
    bit          pcl;
    int unsigned pcv;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  bit          ac_pend = 0;
  int unsigned m_mem[16];
  int unsigned m_ac;
  int unsigned m_e;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: instruction semantics in plain integer arithmetic.
  task automatic predict(input bit i, input int unsigned op, input int unsigned a,
                         output exp_t x);
    bit          memref;
    int unsigned ea, dr, lat, s;
    memref = !(op == 3 || op == 6);
    ea     = (memref && i) ? (m_mem[a] % 16) : a;
    dr     = m_mem[ea];
    if (op == 0 || op == 1 || op == 2 || op == 4) lat = i ? 5 : 3;
    else if (op == 5 || op == 7) lat = i ? 3 : 1;
    else lat = 1;
    x.we = 0; x.waddr = 0; x.wdata = 0; x.pcl = 0; x.pcv = 0;
    case (op)
      0: begin s = m_ac + dr; m_e = (s > 255) ? 1 : 0; m_ac = s % 256; end
      1: begin m_e = (m_ac >= dr) ? 1 : 0; m_ac = (m_ac + 256 - dr) % 256; end
      2: m_ac = m_ac ^ dr;
      3: begin s = 2 * m_ac; m_e = (s > 255) ? 1 : 0; m_ac = s % 256; end
      4: m_ac = dr;
      5: begin x.we = 1; x.waddr = ea; x.wdata = m_ac; m_mem[ea] = m_ac; end
      6: m_ac = 255 - m_ac;
      default: begin x.pcl = 1; x.pcv = ea; end
    endcase
    x.ac       = m_ac;
    x.e        = m_e;
    x.done_cyc = cyc + lat;
  endtask

  // Monitor: retire one expectation per done pulse, then check AC/E after the EXEC edge.
  always @(negedge CLK) begin
    if (RST_N) begin
      if (ac_pend) begin
        check("ac", 32'(AC), cur.ac);
        check("e", 32'(E), cur.e);
        ac_pend = 0;
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'(done), 0);
        end else begin
          cur = q.pop_front();
          check("latency", cyc, cur.done_cyc);
          check("mem_we", 32'(mem_we), 32'(cur.we));
          if (cur.we) begin
            check("sta_addr", 32'(mem_addr), cur.waddr);
            check("sta_wdata", 32'(mem_wdata), cur.wdata);
          end
          check("pc_load", 32'(pc_load), 32'(cur.pcl));
          if (cur.pcl) check("pc_value", 32'(pc_value), cur.pcv);
          ac_pend = 1;
        end
      end else begin
        if (mem_we) check("stray_we", 32'(mem_we), 0);
        if (pc_load) check("stray_pc_load", 32'(pc_load), 0);
      end
    end
  end

  task automatic poke(input int unsigned a, input int unsigned d);
    @(negedge CLK);
    poke_en   = 1;
    poke_addr = 4'(a);
    poke_data = 8'(d);
    m_mem[a]  = d % 256;
    @(negedge CLK);
    poke_en = 0;
  endtask

  // Issue one instruction; returns at the negedge after the start-sampling edge.
  task automatic send(input bit i, input int unsigned op, input int unsigned a);
    exp_t x;
    @(negedge CLK);
    predict(i, op, a, x);
    q.push_back(x);
    start  = 1;
    I      = i;
    opcode = 3'(op);
    addr   = 4'(a);
    @(negedge CLK);
    start = 0;
  endtask

  // Wait for retirement; optionally hammer start with junk while busy (must be ignored).
  task automatic finish_op(input bit noise);
    for (int k = 0; k < 40; k++) begin
      if (busy && noise) begin
        start  = 1'($urandom_range(0, 1));
        I      = 1'($urandom_range(0, 1));
        opcode = 3'($urandom_range(0, 7));
        addr   = 4'($urandom_range(0, 15));
      end else begin
        start = 0;
        if (!busy && q.size() == 0 && !ac_pend) return;
      end
      @(negedge CLK);
    end
    start = 0;
    checks++;
    errors++;
    $display("FAIL op_timeout: pending %0d, expected 0", q.size());
    q.delete();
    ac_pend = 0;
  endtask

  task automatic run(input bit i, input int unsigned op, input int unsigned a, input bit noise);
    send(i, op, a);
    finish_op(noise);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ac"}, 32'(AC), 0);
    check({tag, "_e"}, 32'(E), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pc_load"}, 32'(pc_load), 0);
    check({tag, "_pc_value"}, 32'(pc_value), 0);
  endtask

  initial begin
    RST_N = 0; start = 0; I = 0; opcode = 0; addr = 0;
    poke_en = 0; poke_addr = 0; poke_data = 0;
    m_ac = 0; m_e = 0;
    for (int k = 0; k < 16; k++) poke(k, $urandom_range(0, 255));
    #1;
    check_reset_outputs("rst");
    @(negedge CLK);
    RST_N = 1;

    // Direct ADD with carry out.
    poke(15, 8'hF0);
    run(0, 4, 15, 0);
    poke(3, 8'h20);
    run(0, 0, 3, 0);
    check("add_ac_const", 32'(AC), 32'h10);
    check("add_e_const", 32'(E), 1);

    // Indirect LDA: pointer fetch from 2, operand from 7.
    poke(2, 8'h07);
    poke(7, 8'h5A);
    send(1, 4, 2);
    check("ind_ptr_addr", 32'(mem_addr), 2);
    @(negedge CLK);
    @(negedge CLK);
    check("ind_ea_addr", 32'(mem_addr), 7);
    finish_op(0);
    check("lda_ac_const", 32'(AC), 32'h5A);

    // SUB with borrow, then CMA.
    poke(14, 8'h05);
    run(0, 4, 14, 0);
    poke(1, 8'h09);
    run(0, 1, 1, 0);
    check("sub_ac_const", 32'(AC), 32'hFC);
    check("sub_e_const", 32'(E), 0);
    run(0, 6, 0, 0);
    check("cma_ac_const", 32'(AC), 32'h03);

    // STA direct, then BUN indirect.
    poke(13, 8'h3C);
    run(0, 4, 13, 0);
    run(0, 5, 9, 0);
    check("sta_mem9", 32'(mem[9]), 32'h3C);
    poke(4, 8'h0B);
    run(1, 7, 4, 0);

    // Start pulses while busy are ignored.
    poke(5, 8'h11);
    run(0, 0, 5, 1);

    // Reset during OP_A of an ADD: abandoned, no done, next ADD works.
    send(0, 0, 3);
    check("opa_addr", 32'(mem_addr), 3);
    RST_N = 0;
    q.delete();
    ac_pend = 0;
    m_ac = 0;
    m_e  = 0;
    #1;
    check_reset_outputs("midop");
    repeat (3) @(negedge CLK);
    RST_N = 1;
    repeat (4) @(negedge CLK);
    run(0, 0, 3, 0);
    check("post_rst_ac_const", 32'(AC), 32'h20);

    // Randomized instruction stream with busy-time noise and memory updates.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) poke($urandom_range(0, 15), $urandom_range(0, 255));
      run(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
          1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 16; k++) check("final_mem", 32'(mem[k]), m_mem[k]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is asynchronous and active-low.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 start  input  1  decode-complete strobe; I, opcode and addr are valid in the same cycle.
REQ-005 I  input  1  indirect-address bit from IR[7].
REQ-006 opcode  input  3  operation code from IR[6:4].
REQ-007 addr  input  4  address field from IR[3:0].
REQ-008 mem_addr  output  4  memory address, registered.
REQ-009 mem_rdata  input  8  memory read data, valid in the cycle after mem_addr is presented.
REQ-010 mem_wdata  output  8  memory write data.
REQ-011 mem_we  output  1  memory write enable, one-cycle pulse.
REQ-012 AC  output  8  accumulator.
REQ-013 E  output  1  carry/borrow flag.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 done  output  1  one-cycle pulse, high in the EXEC cycle.
REQ-016 pc_load  output  1  branch request, high only in EXEC of BUN.
REQ-017 pc_value  output  4  branch target; meaningful only while pc_load is high.

Function
REQ-018 Opcodes SHALL be: 000 ADD, 001 SUB, 010 XOR, 011 SHL, 100 LDA, 101 STA, 110 CMA, 111 BUN.
REQ-019 Memory-reference opcodes (000, 001, 010, 100, 101, 111) SHALL use the effective address EA: addr when I=0; mem_rdata[3:0] of M[addr] when I=1.
REQ-020 Register opcodes (011, 110) SHALL ignore I and addr and perform no memory access.
REQ-021 States SHALL be IDLE, IND_A, IND_D, OP_A, OP_D and EXEC.
REQ-022 IDLE + start SHALL latch I, opcode and addr, then go to:
- IND_A if the opcode is memory-reference and I=1;
- else OP_A for 000, 001, 010, 100;
- else EXEC.
REQ-023 IND_A SHALL drive mem_addr=addr, then go to IND_D.
REQ-024 IND_D SHALL capture EA=mem_rdata[3:0], then go to OP_A for 000, 001, 010, 100, else to EXEC.
REQ-025 OP_A SHALL drive mem_addr=EA, then go to OP_D.
REQ-026 OP_D SHALL capture DR=mem_rdata, then go to EXEC.
REQ-027 EXEC SHALL last one cycle, raise done, and return to IDLE.
REQ-028 At the edge ending EXEC, AC and E SHALL update as follows:
- ADD: {E,AC}=AC+DR (9-bit).
- SUB: AC=AC-DR mod 256; E=1 if AC>=DR, else 0.
- XOR: AC=AC^DR; E unchanged.
- SHL: {E,AC}=AC+AC.
- LDA: AC=DR; E unchanged.
- CMA: AC=~AC; E unchanged.
- STA, BUN: AC and E unchanged.
REQ-029 For STA in EXEC, the block SHALL drive mem_addr=EA, mem_wdata=AC and mem_we=1; mem_we SHALL be 0 in every other cycle.
REQ-030 For BUN in EXEC, the block SHALL drive pc_load=1 and pc_value=EA.
REQ-031 Latency from the start-sampling edge to the done cycle SHALL be:
- 3 cycles for direct operand reads;
- 5 cycles for indirect operand reads;
- 1 cycle for register ops and direct STA/BUN;
- 3 cycles for indirect STA/BUN.
REQ-032 start while busy=1 SHALL be ignored with no side effects.
REQ-033 start in the EXEC cycle SHALL be ignored; start SHALL next be accepted in IDLE.
REQ-034 Address arithmetic SHALL be 4-bit; no wrap-around handling is needed beyond the 16-word space.

Reset
REQ-035 RST_N low SHALL immediately force the state to IDLE, including mid-operation.
REQ-036 While RST_N is low, outputs SHALL be: AC=0x00, E=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0, pc_load=0, pc_value=0.
REQ-037 An operation interrupted by reset SHALL be abandoned: no write, no AC update.
REQ-038 The first start after RST_N rises SHALL be processed normally.

Verification
REQ-039 Direct ADD: AC=0xF0, M[3]=0x20, start with I=0, opcode=000, addr=3 -> done 3 cycles later; AC=0x10, E=1.
REQ-040 Indirect LDA: M[2]=0x07, M[7]=0x5A, start with I=1, opcode=100, addr=2 -> mem_addr sequence 2 then 7; done after 5 cycles; AC=0x5A.
REQ-041 SUB borrow: AC=0x05, M[1]=0x09, SUB direct -> AC=0xFC, E=0; then CMA -> AC=0x03 with done 1 cycle after start.
REQ-042 STA then BUN: AC=0x3C, STA direct addr=9 -> single mem_we pulse with mem_addr=9, mem_wdata=0x3C; indirect BUN with M[4]=0x0B, addr=4 -> pc_load=1, pc_value=0xB in EXEC only.
REQ-043 Busy/reset: start pulses during OP_D -> ignored; assert RST_N low in OP_A of ADD -> AC=0, busy=0, no done; the next ADD completes correctly.
